btn_step_conditioner: RTL and testbench
=======================================

// Module: btn_step_conditioner
// PURPOSE
//  Converts one raw, bouncy, asynchronous push-button/switch into clean clk-domain controls for a counter stage.
//  Sits directly upstream of the 4-bit up/down counters on the board.
//  Its single-cycle 'step' pulse drives the counter's count-enable, so one press gives exactly one count.
//  Optional auto-repeat adds periodic steps while the button is held.
// PARAMETERS
//  SYNC_STAGES      2   synchroniser flops on btn_in (>=2)
//  DEBOUNCE_CYCLES  16  stable cycles required to accept a press or a release (>=2)
//  REPEAT_DELAY     64  held cycles after the first step before auto-repeat starts (>=2)
//  REPEAT_RATE      16  cycles between auto-repeat steps (>=2)
//  REPEAT_EN        1   1 = auto-repeat enabled; 0 = one step per press only
// PORTS
//  clk     in   1  system clock
//  rst     in   1  reset, asynchronous, active-high
//  btn_in  in   1  raw button level, asynchronous, active-high, may bounce
//  step    out  1  one-clk pulse per accepted press and per repeat; feeds counter enable
//  level   out  1  debounced button level
// BEHAVIOUR
//  Reset (rst=1, async)
//   - sync chain=0, state=IDLE, cnt=0, step=0, level=0.
//   - Released synchronously to clk.
//  Synchroniser and counter
//   - btn_in passes through SYNC_STAGES flops; s = last stage. The FSM only ever sees s.
//   - cnt is one shared counter, width $clog2(max(DEBOUNCE_CYCLES,REPEAT_DELAY,REPEAT_RATE))+1.
//   - cnt is zeroed on every state change and never wraps.
//  FSM, evaluated on each clk edge
//   - IDLE:         s=1 -> PRESS_CHK.
//   - PRESS_CHK:    s=0 -> IDLE (bounce rejected, no outputs change).
//                   s=1: cnt++; at cnt==DEBOUNCE_CYCLES-1 -> HELD_DELAY, level<=1, step<=1.
//   - HELD_DELAY:   s=0 -> RELEASE_CHK.
//                   s=1: cnt++; if REPEAT_EN and cnt==REPEAT_DELAY-1 -> HELD_REPEAT, step<=1.
//                   If REPEAT_EN=0, stays here while held.
//   - HELD_REPEAT:  s=0 -> RELEASE_CHK.
//                   s=1: cnt++; at cnt==REPEAT_RATE-1 -> cnt<=0, step<=1 (state unchanged).
//   - RELEASE_CHK:  s=1 -> HELD_DELAY (release bounce; no step, repeat delay restarts).
//                   s=0: cnt++; at cnt==DEBOUNCE_CYCLES-1 -> IDLE, level<=0.
//  Outputs
//   - step and level are registered; no combinational path from btn_in.
//   - step is high for exactly one cycle per event; never two consecutive cycles.
//   - level=1 in HELD_DELAY, HELD_REPEAT and RELEASE_CHK; 0 otherwise.
//  Latency
//   - btn_in high and clean from before edge 1: first step is high in the cycle after
//     edge SYNC_STAGES+DEBOUNCE_CYCLES+1 (19 with defaults).
//   - level rises in that same cycle.
//   - Release: level falls SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after btn_in falls.
//   - Repeats: first repeat step REPEAT_DELAY cycles after the first step; then every REPEAT_RATE cycles.
//  Boundary conditions
//   - Glitch shorter than DEBOUNCE_CYCLES (after sync): no step, level unchanged.
//   - rst asserted mid-press: outputs clear immediately.
//     If btn is still held after rst release, a full debounce is required before a new step.
// TESTING
//  1. rst pulse, btn_in=0 for 100 cycles -> step=0, level=0 throughout.
//  2. Clean press at cycle 0, held 40 cycles -> exactly 1 step, in the cycle after edge 19; level=1 from then.
//     REPEAT_EN=0 for this test.
//  3. Press with 5 bounces of 3-cycle width, then stable high; release with 4 bounces ->
//     exactly 1 step, one level rise, one level fall.
//  4. REPEAT_EN=1, hold 200 cycles -> steps after edges 19, 83, 99, 115, ...;
//     release -> no further steps; level falls 19 edges after release.
//  5. Press, then rst at edge 10 while btn_in stays high; rst released at edge 12 ->
//     step/level 0 immediately; next step after edge 12+19=31.
//  6. Drive counter enable from step, 7 clean presses -> counter changes by exactly 7.

Source files
------------

// File: rtl/btn_step_conditioner.sv
// btn_step_conditioner
//   Turns one raw, bouncy, asynchronous push-button into clean clk-domain
//   controls for a counter stage. It produces one single-cycle step per
//   accepted press. Optionally, it adds periodic repeat steps while the
//   button is held.
// Ports
//   clk     in   system clock
//   rst     in   asynchronous, active-high reset
//   btn_in  in   raw button level (asynchronous, may bounce)
//   step    out  registered one-cycle pulse per press / repeat (counter enable)
//   level   out  registered debounced button level
module btn_step_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_RATE     = 16,
  parameter int unsigned REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic step,
  output logic level
);

  localparam int unsigned MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_CYC = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RAT_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESS_CHK   = 3'd1,
    HELD_DELAY  = 3'd2,
    HELD_REPEAT = 3'd3,
    RELEASE_CHK = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic                   step_d, level_d;
  logic [CNT_W-1:0]       cnt_inc;

  // Synchroniser chain; the FSM only looks at the last stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Saturating increment: with repeat disabled a long hold would otherwise wrap.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // State, shared counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      step  <= 1'b0;
      level <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      step  <= step_d;
      level <= level_d;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    step_d  = 1'b0;
    level_d = level;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == DEB_LAST) begin
          state_d = HELD_DELAY;
          cnt_d   = '0;
          level_d = 1'b1;
          step_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD_DELAY: begin
        if (!s) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end else if ((REPEAT_EN != 0) && (cnt == DLY_LAST)) begin
          state_d = HELD_REPEAT;
          cnt_d   = '0;
          step_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD_REPEAT: begin
        if (!s) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end else if (cnt == RAT_LAST) begin
          cnt_d  = '0;
          step_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RELEASE_CHK: begin
        // A return to high is release bounce: no step, and the repeat delay restarts.
        if (s) begin
          state_d = HELD_DELAY;
          cnt_d   = '0;
        end else if (cnt == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_step_conditioner.sv
// tb_btn_step_conditioner
//   Drives two conditioners from the same button, one with auto-repeat and
//   one without. Every cycle, it compares both against a run-length reference
//   model. It also checks the latencies and counts that the datasheet quotes.
module tb_btn_step_conditioner;

  localparam int SYNC  = 2;
  localparam int DEB   = 16;
  localparam int RDLY  = 64;
  localparam int RRATE = 16;
  localparam int LAT   = SYNC + DEB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic step_r, level_r, step_n, level_n;

  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;

  btn_step_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RDLY),
    .REPEAT_RATE(RRATE), .REPEAT_EN(1)
  ) u_rep (
    .clk(clk), .rst(rst), .btn_in(btn), .step(step_r), .level(level_r)
  );

  btn_step_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RDLY),
    .REPEAT_RATE(RRATE), .REPEAT_EN(0)
  ) u_norep (
    .clk(clk), .rst(rst), .btn_in(btn), .step(step_n), .level(level_n)
  );

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model: debounce is a run of DEB+1 equal samples of the synchronised
  // level. Repeats fall at fixed offsets into an unbroken high run after acceptance.
  logic [SYNC-1:0] m_hist = '0;
  logic            m_s;
  bit              m_lvl [2] = '{1'b0, 1'b0};
  bit              m_step[2] = '{1'b0, 1'b0};
  int              m_ones[2] = '{0, 0};
  int              m_zeros[2] = '{0, 0};
  int              m_held[2] = '{0, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hist = '0;
      for (int v = 0; v < 2; v++) begin
        m_lvl[v] = 1'b0; m_step[v] = 1'b0;
        m_ones[v] = 0; m_zeros[v] = 0; m_held[v] = 0;
      end
    end else begin
      m_s    = m_hist[SYNC-1];
      m_hist = {m_hist[SYNC-2:0], btn};
      for (int v = 0; v < 2; v++) begin
        m_step[v] = 1'b0;
        if (!m_lvl[v]) begin
          m_ones[v] = m_s ? m_ones[v] + 1 : 0;
          if (m_ones[v] == DEB + 1) begin
            m_lvl[v] = 1'b1; m_step[v] = 1'b1;
            m_ones[v] = 0; m_zeros[v] = 0; m_held[v] = 0;
          end
        end else if (m_s) begin
          if (m_zeros[v] != 0) begin
            m_zeros[v] = 0; m_held[v] = 0;
          end else begin
            m_held[v]++;
            if (v == 1 && m_held[v] >= RDLY && ((m_held[v] - RDLY) % RRATE) == 0)
              m_step[v] = 1'b1;
          end
        end else begin
          m_zeros[v]++;
          if (m_zeros[v] == DEB + 1) begin
            m_lvl[v] = 1'b0; m_zeros[v] = 0; m_ones[v] = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison plus event bookkeeping for the directed checks.
  int n_step_r = 0, n_step_n = 0, n_rise = 0, n_fall = 0;
  int fall_edge = 0;
  int q_rep[$];
  int q_norep[$];
  logic lvl_prev = 1'b0;

  always @(negedge clk) begin
    chk("step_rep",    int'(step_r),  int'(m_step[1]));
    chk("level_rep",   int'(level_r), int'(m_lvl[1]));
    chk("step_norep",  int'(step_n),  int'(m_step[0]));
    chk("level_norep", int'(level_n), int'(m_lvl[0]));
    if (step_r) begin n_step_r++; q_rep.push_back(edge_cnt); end
    if (step_n) begin n_step_n++; q_norep.push_back(edge_cnt); end
    if (!lvl_prev && level_n) n_rise++;
    if (lvl_prev && !level_n) begin n_fall++; fall_edge = edge_cnt; end
    lvl_prev = level_n;
  end

  logic [3:0] ctr = 4'd0;
  always @(posedge clk) if (step_n) ctr <= ctr + 4'd1;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bounce(input int count, input int width, input logic first);
    for (int i = 0; i < count; i++) begin
      btn = first;  cyc(width);
      btn = ~first; cyc(width);
    end
  endtask

  initial begin
    int base, rel, s0, r0, f0;
    int exp_q[$];
    logic [3:0] c0;

    rst = 1'b1; btn = 1'b0;
    cyc(3);
    chk("reset_step", int'(step_r | step_n), 0);
    chk("reset_level", int'(level_r | level_n), 0);
    rst = 1'b0;

    // Idle line: nothing happens.
    cyc(100);
    chk("idle_steps", n_step_r + n_step_n, 0);
    chk("idle_rises", n_rise, 0);

    // Clean press without repeat: one step after edge LAT.
    q_norep.delete(); s0 = n_step_n;
    base = edge_cnt; btn = 1'b1;
    cyc(40);
    chk("clean_nsteps", n_step_n - s0, 1);
    chk("clean_latency", (q_norep.size() > 0) ? q_norep[0] - base : -1, LAT);
    chk("clean_level", int'(level_n), 1);
    btn = 1'b0;
    cyc(40);
    chk("clean_released", int'(level_n), 0);

    // Bouncy press and release.
    s0 = n_step_n; r0 = n_rise; f0 = n_fall;
    bounce(5, 3, 1'b1);
    btn = 1'b1; cyc(60);
    bounce(4, 3, 1'b0);
    btn = 1'b0; cyc(40);
    chk("bounce_nsteps", n_step_n - s0, 1);
    chk("bounce_rises", n_rise - r0, 1);
    chk("bounce_falls", n_fall - f0, 1);

    // Auto-repeat over a 200-cycle hold.
    q_rep.delete();
    base = edge_cnt; btn = 1'b1;
    cyc(200);
    chk("repeat_level_held", int'(level_r), 1);
    rel = edge_cnt; btn = 1'b0;
    cyc(40);
    exp_q.delete();
    for (int e = LAT; e <= 200 + SYNC; e = (e == LAT) ? e + RDLY : e + RRATE)
      exp_q.push_back(e);
    chk("repeat_count", q_rep.size(), exp_q.size());
    foreach (exp_q[i])
      chk("repeat_edge", (i < q_rep.size()) ? q_rep[i] - base : -1, exp_q[i]);
    chk("release_latency", fall_edge - rel, LAT);

    // Reset mid-press, button held throughout.
    q_norep.delete();
    base = edge_cnt; btn = 1'b1;
    cyc(10);
    rst = 1'b1; #1;
    chk("rst_step_clear", int'(step_n | step_r), 0);
    chk("rst_level_clear", int'(level_n | level_r), 0);
    cyc(2);
    rst = 1'b0;
    cyc(25);
    chk("rst_restart_nsteps", q_norep.size(), 1);
    chk("rst_restart_edge", (q_norep.size() > 0) ? q_norep[0] - base : -1, 12 + LAT);
    chk("rst_restart_level", int'(level_n), 1);
    rst = 1'b1; #1;
    chk("rst_while_high_level", int'(level_n | level_r), 0);
    cyc(1);
    rst = 1'b0; btn = 1'b0;
    cyc(40);

    // Seven clean presses advance the downstream counter by seven.
    c0 = ctr;
    for (int i = 0; i < 7; i++) begin
      btn = 1'b1; cyc($urandom_range(25, 40));
      btn = 1'b0; cyc($urandom_range(25, 40));
    end
    chk("counter_delta", int'(4'(ctr - c0)), 7);

    // Random runs of every length, with occasional resets.
    for (int i = 0; i < 80; i++) begin
      btn = ~btn;
      cyc($urandom_range(1, 45));
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1; cyc($urandom_range(1, 2)); rst = 1'b0;
      end
    end
    btn = 1'b0;
    cyc(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
